// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bus: fetch side (valid/pc/instr/stall), decode side
// (valid/ready/pc/instr), branch flush and occupancy.
// Ports: master = fetch/decode/redirect drivers, slave = the queue itself.
// Signal names keep the queue's point of view (_i into the queue, _o out of it).
interface fetch_queue_if #(
  parameter int PC_BITS = 16,
  parameter int DEPTH   = 4
);
  logic                     valid_i;
  logic [PC_BITS-1:0]       pc_i;
  logic [PC_BITS-1:0]       instr_i;
  logic                     stall_o;
  logic                     flush_i;
  logic                     valid_o;
  logic                     ready_i;
  logic [PC_BITS-1:0]       pc_o;
  logic [PC_BITS-1:0]       instr_o;
  logic [$clog2(DEPTH):0]   count_o;

  modport master (
    output valid_i, pc_i, instr_i, flush_i, ready_i,
    input  stall_o, valid_o, pc_o, instr_o, count_o
  );

  modport slave (
    input  valid_i, pc_i, instr_i, flush_i, ready_i,
    output stall_o, valid_o, pc_o, instr_o, count_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Purpose: circular-buffer queue of {pc, instr} words between fetch and decode.
// Latency: one cycle from push to valid_o (no empty bypass); head is first-word fall-through.
// Backpressure: stall_o high when full, from registered count only; a push is refused
//   while full even if decode pops that same cycle, and fetch re-presents the word.
// Ports: clk_i, rst_n_i (async, active-low), q = fetch_queue_if.slave
//   (valid_i/pc_i/instr_i/stall_o from fetch, valid_o/ready_i/pc_o/instr_o to decode,
//   flush_i redirect, count_o occupancy 0..DEPTH).
// DEPTH must be a power of two (2..16) so the pointers wrap by natural overflow.
module fetch_queue #(
  parameter int PC_BITS = 16,
  parameter int DEPTH   = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  fetch_queue_if.slave  q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PC_BITS-1:0] pc;
    logic [PC_BITS-1:0] instr;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  entry_t head;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Full blocks push regardless of a same-cycle pop: keeps stall_o purely registered.
  assign push = q.valid_i & ~full & ~q.flush_i;
  assign pop  = ~empty & q.ready_i & ~q.flush_i;

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{pc: q.pc_i, instr: q.instr_i};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; outputs are masked by empty instead.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head = mem_q[rd_ptr_q];

  assign q.valid_o = ~empty;
  assign q.stall_o = full;
  assign q.count_o = count_q;
  assign q.pc_o    = empty ? '0 : head.pc;
  assign q.instr_o = empty ? '0 : head.instr;
endmodule
